// File: rtl/uart_tx_if.sv
// Handshake bundle between the UART TX frame controller, its register/FIFO
// source, and the shift-out serializer.
interface uart_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] P_DATA;
  logic             Data_Valid;
  logic             PAR_EN;
  logic             PAR_TYP;
  logic             ser_done;
  logic             ser_data;
  logic             ser_en;
  logic [WIDTH-1:0] ser_p_data;
  logic             TX_OUT;
  logic             busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_done, ser_data,
    input  ser_en, ser_p_data, TX_OUT, busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_done, ser_data,
    output ser_en, ser_p_data, TX_OUT, busy
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART TX frame controller: captures a word, computes parity and sequences
// start / data / parity / stop bits onto TX_OUT, one bit per clock.
module uart_tx_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic      CLK,
  input  logic      RST,
  uart_tx_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] p_data_q;
  logic             par_bit_q;
  logic             par_en_q;
  logic             accept;

  // A new word may be taken while idle or while the stop bit is on the line.
  assign accept = bus.Data_Valid && ((state_q == IDLE) || (state_q == STOP));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      p_data_q  <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
    end else begin
      if (accept) begin
        p_data_q  <= bus.P_DATA;
        par_en_q  <= bus.PAR_EN;
        par_bit_q <= (^bus.P_DATA) ^ bus.PAR_TYP;
      end
      case (state_q)
        IDLE:    state_q <= accept ? START : IDLE;
        START:   state_q <= DATA;
        DATA:    if (bus.ser_done) state_q <= par_en_q ? PARITY : STOP;
        PARITY:  state_q <= STOP;
        STOP:    state_q <= accept ? START : IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ser_p_data = p_data_q;

  always_comb begin
    bus.TX_OUT = 1'b1;
    bus.busy   = 1'b0;
    bus.ser_en = 1'b0;
    case (state_q)
      START: begin
        bus.TX_OUT = 1'b0;
        bus.busy   = 1'b1;
        bus.ser_en = 1'b1;
      end
      DATA: begin
        // Keep shifting until the serializer reports the MSB is on the line.
        bus.TX_OUT = bus.ser_data;
        bus.busy   = 1'b1;
        bus.ser_en = ~bus.ser_done;
      end
      PARITY: begin
        bus.TX_OUT = par_bit_q;
        bus.busy   = 1'b1;
      end
      STOP: begin
        bus.busy   = 1'b1;
      end
      default: begin
        bus.TX_OUT = 1'b1;
        bus.busy   = 1'b0;
        bus.ser_en = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Frame controller for the UART transmitter. It captures a parallel word and computes parity. It sequences the existing shift-out serializer through its ser_en/ser_done handshake. It drives the TX line through start, data, optional parity and stop phases. It sits between the register/FIFO side (Data_Valid, P_DATA) and the serial pin. It runs on the UART TX clock, one bit per clock.

Parameters:
WIDTH, 8, data word width; must match the serializer WIDTH.

Ports:
CLK  input  1  TX bit clock; all state updates on rising edge
RST  input  1  asynchronous active-low reset
P_DATA  input  WIDTH  word to transmit; sampled only on accept
Data_Valid  input  1  single-cycle request to send P_DATA
PAR_EN  input  1  1 = append parity bit; sampled on accept
PAR_TYP  input  1  0 = even, 1 = odd parity; sampled on accept
ser_done  input  1  serializer flag: MSB is currently on ser_data
ser_data  input  1  serializer bit output (registered in serializer)
ser_en  output  1  serializer shift enable
ser_p_data  output  WIDTH  latched word presented to serializer
TX_OUT  output  1  serial line, idle high
busy  output  1  high while a frame is in progress

Behaviour:
- Reset (RST low, async): state IDLE, ser_p_data=0, latched parity=0, latched PAR_EN=0.
  - Outputs at reset: TX_OUT=1, busy=0, ser_en=0.
  - Reset mid-frame aborts the frame immediately; TX_OUT returns to 1 with no stop bit.
- States: IDLE, START, DATA, PARITY, STOP. State register is sequential. Outputs are a combinational decode of state plus registered inputs.
- Accept: Data_Valid=1 in IDLE, or in STOP (back-to-back).
  - On that edge: ser_p_data<=P_DATA, par_en_q<=PAR_EN.
  - par_bit<=(^P_DATA) XOR PAR_TYP.
  - Next state START.
  - Data_Valid in START/DATA/PARITY is ignored (no capture, no queueing).
- IDLE: TX_OUT=1, busy=0, ser_en=0.
- START: TX_OUT=0, busy=1, ser_en=1. Serializer loads bit0 at the closing edge. Next state DATA.
- DATA: TX_OUT=ser_data, busy=1, ser_en=~ser_done.
  - ser_en is therefore high for exactly WIDTH edges per frame (START plus WIDTH-1 DATA cycles).
  - Stay in DATA until ser_done=1. On that cycle (MSB on line): go to PARITY if par_en_q, else STOP.
- PARITY: TX_OUT=par_bit, busy=1, ser_en=0. Next state STOP.
- STOP: TX_OUT=1, busy=1, ser_en=0. Next state START if Data_Valid (accept), else IDLE.
- Frame length: 1+WIDTH+1 cycles without parity; 2+WIDTH+1 with parity. Default: 10 or 11 cycles.
  - Bits are sent LSB first. TX_OUT goes low on the cycle after the accept edge.
- Back-to-back: a STOP accept gives START directly after STOP, with no idle cycle; busy stays 1.
- P_DATA/PAR_EN/PAR_TYP changes after accept do not affect the frame in flight.
- ser_done=1 outside DATA is ignored. No other state consumes ser_done.
- Illegal state encodings recover to IDLE on the next edge.

Test Plan:
- Reset/idle: assert RST low mid-run -> TX_OUT=1, busy=0, ser_en=0 immediately; hold 5 cycles idle -> outputs unchanged.
- Even parity: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, Data_Valid pulse -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1. busy high 11 cycles; ser_en high exactly 8 cycles.
- Odd parity / no parity: 0xA5 with PAR_TYP=1 -> parity bit 1. 0x0F with PAR_EN=0 -> 0,1,1,1,1,0,0,0,0,1 in 10 cycles, no parity slot.
- Ignored request: Data_Valid with P_DATA=0x3C during DATA of a 0x81 frame -> 0x81 frame intact; returns to IDLE; 0x3C never sent.
- Back-to-back: Data_Valid=1 in STOP of frame 0x55 with new P_DATA=0xFF -> START (TX_OUT=0) on the very next cycle; busy never drops; second frame correct.
- Abort: RST low during DATA bit 4 of 0xC3, release, send 0x12 -> TX_OUT=1 during reset; 0x12 frame correct from bit0 (serializer index also reset).
